fetch_operand_a: RTL and testbench

//  FOA stage, directly downstream of instruction fetch (FI) and upstream of fetch-operand-B (FOB).

---
 rtl/fetch_operand_a.sv | 124 ++++++++++++
 tb/tb_fetch_operand_a.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_operand_a.sv
// Fetch-operand-A stage: decodes the opcode, issues the mem[A] read and hands instruction, PC and operand A to FOB.
// Optional writeback bypass of operand A is enabled with the macro FOA_BYPASS_EN.
module fetch_operand_a #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INSTR_WIDTH-1:0] instruction_in,
    input  logic [ADDR_WIDTH-1:0]  program_counter_in,
    input  logic                   instruction_valid_in_from_FI_to_FOA,
    input  logic                   stall,
    input  logic                   flush,
    output logic [ADDR_WIDTH-1:0]  data_mem_read_addr_a,
    output logic                   data_mem_read_en_a,
    input  logic [DATA_WIDTH-1:0]  data_mem_read_data_a,
    input  logic                   wb_write_en,
    input  logic [ADDR_WIDTH-1:0]  wb_write_addr,
    input  logic [DATA_WIDTH-1:0]  wb_write_data,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [ADDR_WIDTH-1:0]  program_counter_out,
    output logic [DATA_WIDTH-1:0]  operand_a_out,
    output logic                   instruction_valid_out_from_FOA_to_FOB
);

    localparam logic [3:0] OP_CP  = 4'b1010;
    localparam logic [3:0] OP_CPI = 4'b1011;

    logic [3:0]            opcode;
    logic                  needs_a;
    logic                  accept;
    logic                  needs_a_q;
    logic                  hold_flag;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  byp_flag;
    logic [DATA_WIDTH-1:0] byp_reg;

    assign opcode               = instruction_in[INSTR_WIDTH-1 -: 4];
    assign needs_a              = (opcode != OP_CP) && (opcode != OP_CPI);
    assign accept               = instruction_valid_in_from_FI_to_FOA & ~stall & ~flush;
    assign data_mem_read_addr_a = instruction_in[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign data_mem_read_en_a   = accept & needs_a;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction_out                       <= '0;
            program_counter_out                   <= '0;
            instruction_valid_out_from_FOA_to_FOB <= 1'b0;
            needs_a_q                             <= 1'b0;
        end else if (flush) begin
            instruction_valid_out_from_FOA_to_FOB <= 1'b0;
        end else if (!stall) begin
            if (instruction_valid_in_from_FI_to_FOA) begin
                instruction_out                       <= instruction_in;
                program_counter_out                   <= program_counter_in;
                instruction_valid_out_from_FOA_to_FOB <= 1'b1;
                needs_a_q                             <= needs_a;
            end else begin
                instruction_valid_out_from_FOA_to_FOB <= 1'b0;
            end
        end
    end

    // Memory data is only valid the cycle after the read, so capture it on the first stalled edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_reg  <= '0;
            hold_flag <= 1'b0;
        end else if (flush) begin
            hold_flag <= 1'b0;
        end else if (stall) begin
            if (instruction_valid_out_from_FOA_to_FOB && !hold_flag) begin
                hold_reg  <= operand_a_out;
                hold_flag <= 1'b1;
            end
        end else begin
            hold_flag <= 1'b0;
        end
    end

`ifdef FOA_BYPASS_EN
    logic [ADDR_WIDTH-1:0] out_a_addr;
    assign out_a_addr = instruction_out[2*ADDR_WIDTH-1:ADDR_WIDTH];

    // Accept-time match covers the memory returning the pre-write value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byp_reg  <= '0;
            byp_flag <= 1'b0;
        end else if (flush) begin
            byp_flag <= 1'b0;
        end else if (accept) begin
            if (wb_write_en && (wb_write_addr == data_mem_read_addr_a)) begin
                byp_reg  <= wb_write_data;
                byp_flag <= 1'b1;
            end else begin
                byp_flag <= 1'b0;
            end
        end else if (instruction_valid_out_from_FOA_to_FOB && wb_write_en &&
                     (wb_write_addr == out_a_addr)) begin
            byp_reg  <= wb_write_data;
            byp_flag <= 1'b1;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_write_en, wb_write_addr, wb_write_data};
    assign byp_flag  = 1'b0;
    assign byp_reg   = '0;
`endif

    always_comb begin
        operand_a_out = data_mem_read_data_a;
        if (!needs_a_q) begin
            operand_a_out = '0;
        end else if (byp_flag) begin
            operand_a_out = byp_reg;
        end else if (hold_flag) begin
            operand_a_out = hold_reg;
        end
    end

endmodule

// File: tb/tb_fetch_operand_a.sv
// Directed bench for fetch_operand_a with a 1-cycle-latency data memory model.
// Compile with FOA_BYPASS_EN defined to expect the bypassed operand in the writeback case.
module tb_fetch_operand_a;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] instruction_in = '0;
    logic [9:0]  program_counter_in = '0;
    logic        valid_in = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [9:0]  rd_addr;
    logic        rd_en;
    logic [31:0] rd_data = '0;
    logic        wb_write_en = 1'b0;
    logic [9:0]  wb_write_addr = '0;
    logic [31:0] wb_write_data = '0;
    logic [23:0] instruction_out;
    logic [9:0]  program_counter_out;
    logic [31:0] operand_a_out;
    logic        valid_out;

    logic [31:0] mem [0:1023];
    logic        corrupt = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_byp;

    always #5 clk = ~clk;

    fetch_operand_a dut (
        .clk                                   (clk),
        .rst                                   (rst),
        .instruction_in                        (instruction_in),
        .program_counter_in                    (program_counter_in),
        .instruction_valid_in_from_FI_to_FOA   (valid_in),
        .stall                                 (stall),
        .flush                                 (flush),
        .data_mem_read_addr_a                  (rd_addr),
        .data_mem_read_en_a                    (rd_en),
        .data_mem_read_data_a                  (rd_data),
        .wb_write_en                           (wb_write_en),
        .wb_write_addr                         (wb_write_addr),
        .wb_write_data                         (wb_write_data),
        .instruction_out                       (instruction_out),
        .program_counter_out                   (program_counter_out),
        .operand_a_out                         (operand_a_out),
        .instruction_valid_out_from_FOA_to_FOB (valid_out)
    );

    // Memory returns mem[addr] one cycle after the strobe; 'corrupt' trashes the bus otherwise.
    always @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[rd_addr];
        else if (corrupt)
            rd_data <= 32'hFF;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [9:0] a, input logic [9:0] pc, input logic v);
        instruction_in     = {op, a, 10'd0};
        program_counter_in = pc;
        valid_in           = v;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5]  = 32'h1234;
        mem[7]  = 32'h7777;
        mem[9]  = 32'hAA;
        mem[12] = 32'h3C;
        mem[3]  = 32'h11;

`ifdef FOA_BYPASS_EN
        exp_byp = 32'h55;
`else
        exp_byp = 32'h11;
`endif

        #3;
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_instr", {8'd0, instruction_out}, 32'd0);
        chk("rst_pc", {22'd0, program_counter_out}, 32'd0);
        chk("rst_opa", operand_a_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("idle_valid", {31'd0, valid_out}, 32'd0);

        // ADD A=5
        drive(4'b0001, 10'd5, 10'h010, 1'b1);
        chk("add_rden", {31'd0, rd_en}, 32'd1);
        chk("add_addr", {22'd0, rd_addr}, 32'd5);
        tick();
        chk("add_valid", {31'd0, valid_out}, 32'd1);
        chk("add_pc", {22'd0, program_counter_out}, 32'h010);
        chk("add_instr", {8'd0, instruction_out}, {8'd0, 4'b0001, 10'd5, 10'd0});
        chk("add_opa", operand_a_out, 32'h1234);

        // CPi A=7: no read, operand forced to 0
        drive(4'b1011, 10'd7, 10'h011, 1'b1);
        chk("cpi_rden", {31'd0, rd_en}, 32'd0);
        tick();
        chk("cpi_valid", {31'd0, valid_out}, 32'd1);
        chk("cpi_pc", {22'd0, program_counter_out}, 32'h011);
        chk("cpi_opa", operand_a_out, 32'd0);

        // ADD A=9 then three stalled cycles with a garbage memory bus
        drive(4'b0001, 10'd9, 10'h012, 1'b1);
        chk("a9_rden", {31'd0, rd_en}, 32'd1);
        tick();
        chk("a9_opa", operand_a_out, 32'hAA);
        stall   = 1'b1;
        corrupt = 1'b1;
        drive(4'b0001, 10'd12, 10'h013, 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk("stall_rden", {31'd0, rd_en}, 32'd0);
            tick();
            chk("stall_opa", operand_a_out, 32'hAA);
            chk("stall_pc", {22'd0, program_counter_out}, 32'h012);
            chk("stall_valid", {31'd0, valid_out}, 32'd1);
        end
        chk("stall_bus", rd_data, 32'hFF);
        stall   = 1'b0;
        corrupt = 1'b0;
        #1;
        chk("unstall_rden", {31'd0, rd_en}, 32'd1);
        chk("unstall_addr", {22'd0, rd_addr}, 32'd12);
        tick();
        chk("unstall_pc", {22'd0, program_counter_out}, 32'h013);
        chk("unstall_opa", operand_a_out, 32'h3C);

        // Flush and stall together while valid_out is high
        stall = 1'b1;
        flush = 1'b1;
        drive(4'b0001, 10'd5, 10'h020, 1'b1);
        chk("flush_rden", {31'd0, rd_en}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        stall = 1'b0;
        flush = 1'b0;
        #1;
        chk("post_flush_rden", {31'd0, rd_en}, 32'd1);
        tick();
        chk("post_flush_valid", {31'd0, valid_out}, 32'd1);
        chk("post_flush_pc", {22'd0, program_counter_out}, 32'h020);
        chk("post_flush_opa", operand_a_out, 32'h1234);

        // Bubble
        drive(4'b0001, 10'd5, 10'h021, 1'b0);
        chk("bubble_rden", {31'd0, rd_en}, 32'd0);
        tick();
        chk("bubble_valid", {31'd0, valid_out}, 32'd0);

        // Writeback to A=3 in the accept cycle; memory returns stale 0x11
        wb_write_en   = 1'b1;
        wb_write_addr = 10'd3;
        wb_write_data = 32'h55;
        drive(4'b0001, 10'd3, 10'h030, 1'b1);
        tick();
        wb_write_en = 1'b0;
        valid_in    = 1'b0;
        chk("byp_valid", {31'd0, valid_out}, 32'd1);
        chk("byp_opa", operand_a_out, exp_byp);

        // Asynchronous reset mid-stream
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid_out}, 32'd0);
        chk("arst_pc", {22'd0, program_counter_out}, 32'd0);
        chk("arst_instr", {8'd0, instruction_out}, 32'd0);
        chk("arst_opa", operand_a_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("arst_idle_valid", {31'd0, valid_out}, 32'd0);
        drive(4'b0001, 10'd7, 10'h040, 1'b1);
        tick();
        chk("arst_acc_valid", {31'd0, valid_out}, 32'd1);
        chk("arst_acc_opa", operand_a_out, 32'h7777);
        valid_in = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
